// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file: default word width,
// clear/run state encodings and the hard-wired zero register address.
package regfile_mp_pkg;

  localparam int unsigned WORD_LEN = 32;
  localparam int unsigned REG_ZERO = 0;

  localparam logic [0:0] RF_CLEAR = 1'b0;
  localparam logic [0:0] RF_RUN   = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: set by a decode claim, cleared by the
// matching writeback. A claim beats a clear to the same register.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                claim_en,
  input  logic [ADDR_W-1:0]   claim_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] pending
);

  // Claim is applied last so it overrides a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (en) begin
      if (clr_en)   pending[clr_addr]   <= 1'b0;
      if (claim_en) pending[claim_addr] <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: configurable read ports, optional write bypass,
// hard-wired zero register, sequential clear after reset and hazard scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W         = WORD_LEN,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned NUM_RD         = 2,
  parameter int unsigned BYPASS         = 1,
  parameter int unsigned ZERO_REG       = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [0:0]          state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                wr_ok;
  logic                claim_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? RF_CLEAR : RF_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Clear walks every entry once, then hands over to normal operation.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      RF_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = RF_RUN;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy     = (state_q == RF_CLEAR);
  assign wr_ok    = !busy && wr_en
                    && !((ZERO_REG != 0) && (wr_addr == ZERO_ADDR));
  assign claim_ok = !busy && claim_en
                    && !((ZERO_REG != 0) && (claim_addr == ZERO_ADDR));

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy)       mem[clr_cnt_q] <= '0;
      else if (wr_ok) mem[wr_addr]   <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .en         (!busy),
    .claim_en   (claim_ok),
    .claim_addr (claim_addr),
    .clr_en     (wr_ok),
    .clr_addr   (wr_addr),
    .pending    (pending)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              p;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    // A same-cycle claim only shows up next cycle, so bypass reports the stored bit.
    always_comb begin
      d = mem[a];
      p = pending[a];
      if (busy || ((ZERO_REG != 0) && (a == ZERO_ADDR))) begin
        d = '0;
        p = 1'b0;
      end else if ((BYPASS != 0) && wr_ok && (wr_addr == a)) begin
        d = wr_data;
        p = (claim_ok && (claim_addr == a)) ? pending[a] : 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_pending[k]               = p;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the pipeline register file.
- Configurable width, depth and read-port count; posedge write; optional write-to-read bypass; hard-wired zero register.
- Sequential clear after reset; per-register pending-write scoreboard for decode-stage hazard detection.
- Sits between decode (reads, claims) and writeback (writes).

Parameters:
- DATA_W, 32, data word width (matches WORD_LEN)
- ADDR_W, 5, register address width
- NUM_REGS, 32, register count; must equal 2**ADDR_W
- NUM_RD, 2, number of combinational read ports
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and claims
- CLEAR_ON_RESET, 1, 1 = zero all entries sequentially after reset

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational
- rd_pending  out  NUM_RD  pending bit of each addressed register, combinational
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- claim_en  in  1  mark a register as awaiting a write (instruction issued)
- claim_addr  in  ADDR_W  register being claimed
- busy  out  1  clear sequence in progress

Behaviour:
- States: CLEAR, RUN.
- rst high at posedge: state <= (CLEAR_ON_RESET ? CLEAR : RUN); clr_cnt <= 0; all pending bits <= 0.
- busy = (state == CLEAR); combinational, so busy = 1 in the first cycle after reset when CLEAR_ON_RESET = 1.
- CLEAR: each posedge writes mem[clr_cnt] <= 0 and increments clr_cnt. When clr_cnt == NUM_REGS-1, go to RUN. busy is high for exactly NUM_REGS cycles after rst falls.
- CLEAR_ON_RESET = 0: array contents are untouched by reset; busy is never asserted.
- While busy:
  - wr_en and claim_en are ignored; no memory or scoreboard change.
  - rd_data = 0 and rd_pending = 0 on all ports.
- rst asserted mid-clear: restart from clr_cnt = 0; entries already zeroed stay zero.
- Write, RUN only:
  - At posedge with wr_en, mem[wr_addr] <= wr_data and pending[wr_addr] <= 0.
  - ZERO_REG = 1 and wr_addr == 0: the write is dropped.
- Claim, RUN only:
  - At posedge with claim_en, pending[claim_addr] <= 1.
  - Ignored for address 0 when ZERO_REG = 1.
- Claim and write to the same address in one cycle: claim wins, pending stays 1 (a newer producer has issued); the data write still occurs.
- Read, per port k, purely combinational:
  - ZERO_REG = 1 and address 0: rd_data = 0, rd_pending = 0.
  - Otherwise, if BYPASS = 1 and wr_en and wr_addr == rd_addr[k]: rd_data = wr_data, and rd_pending = 0 unless a same-cycle claim targets that address (the claim becomes visible next cycle).
  - Otherwise: rd_data = mem[rd_addr[k]], rd_pending = pending[rd_addr[k]].
- BYPASS = 0: a write becomes visible one cycle after its posedge; reads in the write cycle return the old value.
- Multiple read ports may address the same register; each returns identical data.
- Write-then-read latency: 0 cycles with bypass, 1 cycle without.
- No reset value applies to rd_data beyond the busy forcing above; it is combinational from state.

Decomposition:
- Shared defines/package:
  - WORD_LEN (reused as the DATA_W default)
  - state encodings RF_CLEAR = 1'b0, RF_RUN = 1'b1
  - REG_ZERO = 0 address constant
- Sub-module regfile_scoreboard:
  - parameters NUM_REGS, ADDR_W
  - inputs: clk, rst, en (= !busy), claim_en/claim_addr, clr_en/clr_addr
  - NUM_REGS-bit pending vector output; claim-over-clear priority inside
- Top level holds the array, the clear FSM, bypass muxes and the read-port generate loop.

Test Plan:
- Reset clear: preload mem[7] = 0xDEAD, pulse rst 1 cycle -> busy high exactly 32 cycles; then port0 addr 7 reads 0x00000000; wr_en during busy has no effect.
- Bypass: RUN, wr_en=1, wr_addr=5, wr_data=0x12345678, rd_addr0=5 in the same cycle -> rd_data0 = 0x12345678 that cycle; with BYPASS=0 -> old value that cycle, new value next cycle.
- Zero register: write 0xFFFFFFFF to addr 0, claim addr 0 -> port reads 0, rd_pending = 0 in all following cycles.
- Scoreboard: claim addr 9 -> rd_pending = 1 next cycle; write addr 9 = 0xA5 three cycles later -> pending 0 (same cycle with bypass); simultaneous claim and write to 9 -> pending stays 1, data = new value.
- Multi-port (NUM_RD=4): four ports read addrs 1, 2, 2, 31 after writing 0x11, 0x22, 0x1F -> 0x11, 0x22, 0x22, 0x1F.
- Reset mid-clear: assert rst at clear cycle 10 -> busy continues for a full 32 cycles after rst falls; all entries read 0 afterwards.
